// File: rtl/word_bit_serializer_if.sv
// word_bit_serializer_if: parallel-word handshake in, qualified serial bit stream out.
interface word_bit_serializer_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] in_data;
    logic in_valid;
    logic in_ready;
    logic stall;
    logic out_bit;
    logic out_valid;
    logic word_done;
    logic busy;
    modport master (output in_data, in_valid, stall, input in_ready, out_bit, out_valid, word_done, busy);
    modport slave (input in_data, in_valid, stall, output in_ready, out_bit, out_valid, word_done, busy);
endinterface

// File: rtl/word_bit_serializer.sv
// word_bit_serializer: streams WIDTH-bit words one bit per clock, with a one-word hold register for gapless back-to-back words.
module word_bit_serializer #(
    parameter int WIDTH = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic clk,
    input logic rst,
    word_bit_serializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] sh, sh_n, hd, hd_n, shifted;
    logic [CW-1:0] cnt, cnt_n;
    logic hold_full, hold_full_n;
    logic acc;
    assign acc = bus.in_valid && !hold_full;
    assign shifted = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
    assign bus.in_ready = !hold_full;
    assign bus.out_bit = MSB_FIRST ? sh[WIDTH-1] : sh[0];
    assign bus.out_valid = (state == SHIFT) && !bus.stall;
    assign bus.word_done = bus.out_valid && (cnt == CW'(WIDTH - 1));
    assign bus.busy = (state == SHIFT) || hold_full;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sh <= '0;
            hd <= '0;
            cnt <= '0;
            hold_full <= 1'b0;
        end else begin
            state <= state_n;
            sh <= sh_n;
            hd <= hd_n;
            cnt <= cnt_n;
            hold_full <= hold_full_n;
        end
    end
    // Word boundary: the hold register takes priority over a fresh word so order is kept.
    always_comb begin
        state_n = state;
        sh_n = sh;
        hd_n = hd;
        cnt_n = cnt;
        hold_full_n = hold_full;
        if (state == IDLE) begin
            if (acc) begin
                sh_n = bus.in_data;
                cnt_n = '0;
                state_n = SHIFT;
            end
        end else begin
            if (bus.out_valid) begin
                sh_n = shifted;
                cnt_n = cnt + CW'(1);
            end
            if (!bus.word_done) begin
                if (acc) begin
                    hd_n = bus.in_data;
                    hold_full_n = 1'b1;
                end
            end else if (hold_full) begin
                sh_n = hd;
                cnt_n = '0;
                hold_full_n = 1'b0;
            end else if (acc) begin
                sh_n = bus.in_data;
                cnt_n = '0;
            end else begin
                state_n = IDLE;
            end
        end
    end
endmodule

// File: tb/tb_word_bit_serializer.sv
// tb_word_bit_serializer: directed checks of an MSB-first and an LSB-first serializer fed the same stream,
// plus an end-to-end 1011 sequence detector driven by the LSB-first bit stream.
module tb_word_bit_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    word_bit_serializer_if #(.WIDTH(8)) bus0 ();
    word_bit_serializer_if #(.WIDTH(8)) bus1 ();
    assign bus1.in_data = bus0.in_data;
    assign bus1.in_valid = bus0.in_valid;
    assign bus1.stall = bus0.stall;

    word_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bus0));
    word_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bus1));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic ov[64], ob[64], ob1[64], wd[64], rdy[64], bsy[64];

    // Producer: presents words in order, advancing only on an accepted handshake; records per-cycle outputs.
    task automatic run(input logic [7:0] w[$], input logic [63:0] stall_mask, input int ncyc);
        int idx = 0;
        logic acc;
        for (int c = 0; c < ncyc; c++) begin
            bus0.in_valid = idx < w.size();
            bus0.in_data = (idx < w.size()) ? w[idx] : 8'h00;
            bus0.stall = stall_mask[c];
            @(negedge clk);
            ov[c] = bus0.out_valid;
            ob[c] = bus0.out_bit;
            ob1[c] = bus1.out_bit;
            wd[c] = bus0.word_done;
            rdy[c] = bus0.in_ready;
            bsy[c] = bus0.busy;
            acc = bus0.in_valid && bus0.in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        bus0.in_valid = 1'b0;
        bus0.stall = 1'b0;
    endtask

    function automatic logic [31:0] stream(input int ncyc, input bit lsb);
        logic [31:0] v = '0;
        for (int c = 0; c < ncyc; c++) if (ov[c]) v = {v[30:0], lsb ? ob1[c] : ob[c]};
        return v;
    endfunction

    function automatic int count_ov(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) n += int'(ov[c]);
        return n;
    endfunction

    function automatic int count_wd(input int ncyc);
        int n = 0;
        for (int c = 0; c < ncyc; c++) n += int'(wd[c]);
        return n;
    endfunction

    function automatic int first_wd(input int ncyc);
        for (int c = 0; c < ncyc; c++) if (wd[c]) return c;
        return -1;
    endfunction

    // Downstream 1011 recogniser (overlapping), clock-enabled by out_valid.
    logic [1:0] ds;
    logic det;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ds <= 2'd0;
            det <= 1'b0;
        end else if (bus1.out_valid) begin
            det <= (ds == 2'd3) && bus1.out_bit;
            case (ds)
                2'd0: ds <= bus1.out_bit ? 2'd1 : 2'd0;
                2'd1: ds <= bus1.out_bit ? 2'd1 : 2'd2;
                2'd2: ds <= bus1.out_bit ? 2'd3 : 2'd0;
                default: ds <= bus1.out_bit ? 2'd1 : 2'd2;
            endcase
        end
    end

    logic exp_bits[800], exp_flag[800];
    logic e2e_on = 1'b0;
    int k = 0;
    always @(negedge clk) begin
        if (e2e_on && bus1.out_valid) begin
            if (k > 0 && k <= 800) check("e2e_det", 32'(det), 32'(exp_flag[k-1]));
            if (k < 800) check("e2e_bit", 32'(bus1.out_bit), 32'(exp_bits[k]));
            k++;
        end
    end

    initial begin
        logic [7:0] rw[$];
        int idx;
        logic acc;
        bus0.in_valid = 1'b0;
        bus0.in_data = 8'h00;
        bus0.stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus0.out_valid), 0);
        check("rst_busy", 32'(bus0.busy), 0);
        check("rst_in_ready", 32'(bus0.in_ready), 1);
        rst = 1'b0;

        run('{8'hA5}, 64'd0, 12);
        check("single_bits", stream(12, 0), 32'h000000A5);
        check("single_first_valid", 32'(ov[1]), 1);
        check("single_nvalid", 32'(count_ov(0, 11)), 8);
        check("single_done_at", 32'(first_wd(12)), 8);
        check("single_ndone", 32'(count_wd(12)), 1);
        check("single_busy_after", 32'(bsy[9]), 0);

        run('{8'hF0, 8'h0F, 8'h3C}, 64'd0, 30);
        check("stream_bits", stream(30, 0), 32'h00F00F3C);
        check("stream_contig", 32'(count_ov(1, 24)), 24);
        check("stream_nvalid", 32'(count_ov(0, 29)), 24);
        check("stream_ndone", 32'(count_wd(30)), 3);
        check("stream_rdy_c2", 32'(rdy[2]), 0);
        check("stream_rdy_c8", 32'(rdy[8]), 0);
        check("stream_rdy_c9", 32'(rdy[9]), 1);
        check("stream_busy_end", 32'(bsy[25]), 0);

        run('{8'hC3}, 64'h38, 16);
        check("stall_bits", stream(16, 0), 32'h000000C3);
        check("stall_valid_gap", 32'(count_ov(3, 5)), 0);
        check("stall_bit_held", {29'd0, ob[3], ob[4], ob[5]}, 32'h0);
        check("stall_bit_resume", 32'(ob[6]), 0);
        check("stall_done_at", 32'(first_wd(16)), 11);
        check("stall_ndone", 32'(count_wd(16)), 1);

        run('{8'hFF, 8'h55}, 64'd0, 3);
        check("midrst_valid_before", 32'(bus0.out_valid), 1);
        check("midrst_hold_full", 32'(bus0.in_ready), 0);
        rst = 1'b1;
        bus0.in_valid = 1'b1;
        bus0.in_data = 8'hAA;
        #1;
        check("midrst_out_valid", 32'(bus0.out_valid), 0);
        check("midrst_word_done", 32'(bus0.word_done), 0);
        check("midrst_busy", 32'(bus0.busy), 0);
        check("midrst_in_ready", 32'(bus0.in_ready), 1);
        check("midrst_out_bit", 32'(bus0.out_bit), 0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_no_accept", 32'(bus0.busy), 0);
        bus0.in_valid = 1'b0;
        rst = 1'b0;
        run('{8'h81}, 64'd0, 14);
        check("post_rst_bits", stream(14, 0), 32'h00000081);
        check("post_rst_nvalid", 32'(count_ov(0, 13)), 8);

        run('{8'h01}, 64'd0, 12);
        check("lsb_bits", stream(12, 1), 32'h00000080);
        check("lsb_first_bit", 32'(ob1[1]), 1);
        check("lsb_nvalid", 32'(count_ov(0, 11)), 8);

        for (int i = 0; i < 100; i++) begin
            rw.push_back(8'($urandom_range(0, 255)));
            for (int b = 0; b < 8; b++) exp_bits[i*8+b] = rw[i][b];
        end
        for (int i = 0; i < 800; i++)
            exp_flag[i] = (i >= 3) && exp_bits[i-3] && !exp_bits[i-2] && exp_bits[i-1] && exp_bits[i];
        rst = 1'b1;
        #1;
        rst = 1'b0;
        e2e_on = 1'b1;
        idx = 0;
        for (int c = 0; c < 3000 && (idx < 100 || bus0.busy); c++) begin
            bus0.in_valid = idx < 100;
            bus0.in_data = (idx < 100) ? rw[idx] : 8'h00;
            bus0.stall = $urandom_range(0, 3) == 0;
            @(negedge clk);
            acc = bus0.in_valid && bus0.in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        bus0.in_valid = 1'b0;
        bus0.stall = 1'b0;
        @(negedge clk);
        e2e_on = 1'b0;
        check("e2e_words", 32'(idx), 100);
        check("e2e_nbits", 32'(k), 800);
        check("e2e_det_last", 32'(det), 32'(exp_flag[799]));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
